// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
// Configuration macro: RF_BYPASS_EN (see regfile_wb_scheduler.sv).
package rf_sched_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;

    localparam int       STARVE_MAX_DEF = 4;
    localparam reg_idx_t ZERO           = '0;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Two-way writeback arbiter: LSU over ALU, with an ALU
// starvation counter that forces an ALU win at STARVE_MAX.
module wb_arbiter
    import rf_sched_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    alu_valid_i,
    input  logic    lsu_valid_i,
    output logic    alu_ready_o,
    output logic    lsu_ready_o,
    output wb_src_e grant_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

    logic [3:0] cnt_q, cnt_d;
    logic       force_alu;

    assign force_alu = (cnt_q == LIMIT);

    always_comb begin
        grant_o = WB_NONE;
        if (!rst) begin
            if (alu_valid_i && (!lsu_valid_i || force_alu))
                grant_o = WB_ALU;
            else if (lsu_valid_i)
                grant_o = WB_LSU;
        end
    end

    assign alu_ready_o = (grant_o == WB_ALU);
    assign lsu_ready_o = (grant_o == WB_LSU);

    // Saturate at LIMIT so a denial during reset cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_o == WB_ALU)
            cnt_d = '0;
        else if (alu_valid_i && !force_alu)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Scoreboard, hazard check and registered write port for the RF.
// Optional forwarding path enabled by defining RF_BYPASS_EN.
module regfile_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int NREGS      = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid_i,
    input  reg_idx_t          issue_rs1_i,
    input  reg_idx_t          issue_rs2_i,
    input  reg_idx_t          issue_rd_i,
    input  logic              issue_wr_i,
    output logic              issue_stall_o,
    input  logic              alu_valid_i,
    input  reg_idx_t          alu_rd_i,
    input  logic [DWIDTH-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              lsu_valid_i,
    input  reg_idx_t          lsu_rd_i,
    input  logic [DWIDTH-1:0] lsu_data_i,
    output logic              lsu_ready_o,
    output reg_idx_t          rf_rd_o,
    output logic [DWIDTH-1:0] rf_data_o,
    output logic              rf_wren_o,
    output logic [NREGS-1:0]  busy_o,
    output logic              wb_err_o
`ifdef RF_BYPASS_EN
    ,
    output logic              fwd_rs1_o,
    output logic              fwd_rs2_o,
    output logic [DWIDTH-1:0] fwd_data_o
`endif
);

    logic [NREGS-1:0]  busy_q, busy_d, busy_eff;
    reg_idx_t          rf_rd_q, rf_rd_d;
    logic [DWIDTH-1:0] rf_data_q, rf_data_d;
    logic              rf_wren_q, rf_wren_d;
    logic              wb_err_q, wb_err_d;
    wb_src_e           grant;
    reg_idx_t          wb_rd;
    logic [DWIDTH-1:0] wb_data;
    logic              issue_fire;

    wb_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .alu_valid_i (alu_valid_i),
        .lsu_valid_i (lsu_valid_i),
        .alu_ready_o (alu_ready_o),
        .lsu_ready_o (lsu_ready_o),
        .grant_o     (grant)
    );

    // A write still in flight when reset hits never reaches the RF.
    assign rf_wren_o = rf_wren_q & ~rst;
    assign rf_rd_o   = rf_rd_q;
    assign rf_data_o = rf_data_q;
    assign busy_o    = busy_q;
    assign wb_err_o  = wb_err_q;

`ifdef RF_BYPASS_EN
    always_comb begin
        busy_eff = busy_q;
        if (rf_wren_o)
            busy_eff[rf_rd_q] = 1'b0;
    end

    assign fwd_rs1_o  = rf_wren_o & (rf_rd_q == issue_rs1_i);
    assign fwd_rs2_o  = rf_wren_o & (rf_rd_q == issue_rs2_i);
    assign fwd_data_o = rf_data_q;
`else
    assign busy_eff = busy_q;
`endif

    assign issue_stall_o = rst | (issue_valid_i &
        (busy_eff[issue_rs1_i] | busy_eff[issue_rs2_i] |
         (issue_wr_i & busy_eff[issue_rd_i])));

    assign issue_fire = issue_valid_i & ~issue_stall_o;

    always_comb begin
        wb_rd   = ZERO;
        wb_data = '0;
        unique case (grant)
            WB_ALU: begin
                wb_rd   = alu_rd_i;
                wb_data = alu_data_i;
            end
            WB_LSU: begin
                wb_rd   = lsu_rd_i;
                wb_data = lsu_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        rf_wren_d = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        wb_err_d  = wb_err_q;
        if (grant != WB_NONE) begin
            rf_wren_d = (wb_rd != ZERO);
            rf_rd_d   = wb_rd;
            rf_data_d = wb_data;
            if (wb_rd != ZERO && !busy_q[wb_rd])
                wb_err_d = 1'b1;
        end
    end

    // Clear first, then set: a same-edge set of one bit wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_wren_q)
            busy_d[rf_rd_q] = 1'b0;
        if (issue_fire && issue_wr_i && issue_rd_i != ZERO)
            busy_d[issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            rf_wren_q <= 1'b0;
            rf_rd_q   <= ZERO;
            rf_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            rf_wren_q <= rf_wren_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_regfile_wb_scheduler;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_i, issue_wr_i;
    logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i;
    logic        issue_stall_o;
    logic        alu_valid_i, alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i, lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;
    logic        rf_wren_o;
    logic [31:0] busy_o;
    logic        wb_err_o;
`ifdef RF_BYPASS_EN
    logic        fwd_rs1_o, fwd_rs2_o;
    logic [31:0] fwd_data_o;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [31:0] busy_m;
    int          cnt_m;
    logic        wren_m;
    logic [4:0]  rd_m;
    logic [31:0] data_m;
    logic        err_m;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid_i),
        .issue_rs1_i   (issue_rs1_i),
        .issue_rs2_i   (issue_rs2_i),
        .issue_rd_i    (issue_rd_i),
        .issue_wr_i    (issue_wr_i),
        .issue_stall_o (issue_stall_o),
        .alu_valid_i   (alu_valid_i),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .alu_ready_o   (alu_ready_o),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_rd_i      (lsu_rd_i),
        .lsu_data_i    (lsu_data_i),
        .lsu_ready_o   (lsu_ready_o),
        .rf_rd_o       (rf_rd_o),
        .rf_data_o     (rf_data_o),
        .rf_wren_o     (rf_wren_o),
        .busy_o        (busy_o),
        .wb_err_o      (wb_err_o)
`ifdef RF_BYPASS_EN
        ,
        .fwd_rs1_o     (fwd_rs1_o),
        .fwd_rs2_o     (fwd_rs2_o),
        .fwd_data_o    (fwd_data_o)
`endif
    );

    function automatic logic m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return busy_m[r] && !(BYP && wren_m && !rst && rd_m == r);
    endfunction

    function automatic logic m_stall();
        return rst || (issue_valid_i && (m_busy(issue_rs1_i) ||
            m_busy(issue_rs2_i) || (issue_wr_i && m_busy(issue_rd_i))));
    endfunction

    // 0 = none, 1 = ALU, 2 = LSU
    function automatic int m_grant();
        if (rst) return 0;
        if (alu_valid_i && (!lsu_valid_i || cnt_m >= SMAX)) return 1;
        if (lsu_valid_i) return 2;
        return 0;
    endfunction

    task automatic step();
        int          g;
        logic        fire;
        logic [4:0]  wrd;
        logic [31:0] wdat, nb;
        g    = m_grant();
        fire = issue_valid_i && !m_stall();
        wrd  = (g == 1) ? alu_rd_i : lsu_rd_i;
        wdat = (g == 1) ? alu_data_i : lsu_data_i;
        @(posedge clk);
        if (rst) begin
            busy_m = '0; cnt_m = 0; wren_m = 1'b0;
            rd_m = '0; data_m = '0; err_m = 1'b0;
        end else begin
            nb = busy_m;
            if (wren_m) nb[rd_m] = 1'b0;
            if (fire && issue_wr_i && issue_rd_i != 0) nb[issue_rd_i] = 1'b1;
            nb[0] = 1'b0;
            if (g != 0) begin
                if (wrd != 0 && !busy_m[wrd]) err_m = 1'b1;
                wren_m = (wrd != 0);
                rd_m   = wrd;
                data_m = wdat;
            end else begin
                wren_m = 1'b0;
            end
            if (g == 1) cnt_m = 0;
            else if (alu_valid_i) cnt_m = cnt_m + 1;
            busy_m = nb;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_valid_i = 0; issue_wr_i = 0;
        issue_rs1_i = 0; issue_rs2_i = 0; issue_rd_i = 0;
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        alu_valid_i = 1; lsu_valid_i = 1;
        issue_valid_i = 1;
        step(); step();
        #1;
        total++; if (busy_o !== 32'h0) begin bad++;
            $display("FAIL rst_busy: got %0h want 0", busy_o); end
        total++; if (rf_wren_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_data_o !== 32'h0) begin bad++;
            $display("FAIL rst_wport: got %0b/%0h/%0h want 0/0/0", rf_wren_o, rf_rd_o, rf_data_o); end
        total++; if (wb_err_o !== 1'b0) begin bad++;
            $display("FAIL rst_err: got %0b want 0", wb_err_o); end
        total++; if (issue_stall_o !== 1'b1 || alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin bad++;
            $display("FAIL rst_hs: got stall=%0b ar=%0b lr=%0b want 1/0/0",
                     issue_stall_o, alu_ready_o, lsu_ready_o); end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_raw();
        issue_valid_i = 1; issue_wr_i = 1; issue_rd_i = 5;
        #1;
        total++; if (issue_stall_o !== 1'b0) begin bad++;
            $display("FAIL raw_first: got %0b want 0", issue_stall_o); end
        step();
        issue_wr_i = 0; issue_rd_i = 0; issue_rs1_i = 5;
        alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'h1234;
        #1;
        total++; if (issue_stall_o !== 1'b1 || alu_ready_o !== 1'b1) begin bad++;
            $display("FAIL raw_grant: got stall=%0b ar=%0b want 1/1", issue_stall_o, alu_ready_o); end
        step();
        alu_valid_i = 0;
        #1;
        total++; if (rf_wren_o !== 1'b1 || rf_rd_o !== 5'd5 || rf_data_o !== 32'h1234) begin bad++;
            $display("FAIL raw_write: got %0b/%0h/%0h want 1/5/1234", rf_wren_o, rf_rd_o, rf_data_o); end
        total++; if (issue_stall_o !== !BYP) begin bad++;
            $display("FAIL raw_n1_stall: got %0b want %0b", issue_stall_o, !BYP); end
        step();
        #1;
        total++; if (issue_stall_o !== 1'b0 || rf_wren_o !== 1'b0 || busy_o[5] !== 1'b0) begin bad++;
            $display("FAIL raw_n2: got stall=%0b wren=%0b busy5=%0b want 0/0/0",
                     issue_stall_o, rf_wren_o, busy_o[5]); end
        idle_inputs();
        step();
    endtask

    task automatic test_starvation();
        int lsu_before = 0;
        int alu_at = 0;
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'h11;
        lsu_valid_i = 1; lsu_rd_i = 0; lsu_data_i = 32'h22;
        for (int i = 1; i <= 6; i++) begin
            #1;
            total++; if ((alu_ready_o ^ lsu_ready_o) !== 1'b1) begin bad++;
                $display("FAIL starve_excl: cyc %0d got ar=%0b lr=%0b want one grant",
                         i, alu_ready_o, lsu_ready_o); end
            if (alu_ready_o === 1'b1 && alu_at == 0) alu_at = i;
            if (lsu_ready_o === 1'b1 && alu_at == 0) lsu_before++;
            if (i == 6) begin
                total++; if (lsu_ready_o !== 1'b1) begin bad++;
                    $display("FAIL starve_cleared: got lr=%0b want 1", lsu_ready_o); end
            end
            step();
        end
        total++; if (lsu_before != SMAX || alu_at != SMAX + 1) begin bad++;
            $display("FAIL starve_order: got lsu=%0d alu_at=%0d want %0d/%0d",
                     lsu_before, alu_at, SMAX, SMAX + 1); end
        idle_inputs();
        step();
    endtask

    task automatic test_rd0();
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'hFFFF;
        #1;
        total++; if (alu_ready_o !== 1'b1) begin bad++;
            $display("FAIL rd0_ready: got %0b want 1", alu_ready_o); end
        step();
        alu_valid_i = 0;
        #1;
        total++; if (rf_wren_o !== 1'b0 || busy_o !== busy_m) begin bad++;
            $display("FAIL rd0_nowrite: got wren=%0b busy=%0h want 0/%0h",
                     rf_wren_o, busy_o, busy_m); end
        step();
    endtask

    task automatic test_err();
        #1;
        total++; if (wb_err_o !== 1'b0 || busy_o[7] !== 1'b0) begin bad++;
            $display("FAIL err_pre: got err=%0b busy7=%0b want 0/0", wb_err_o, busy_o[7]); end
        lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'h77;
        step();
        lsu_valid_i = 0;
        #1;
        total++; if (rf_wren_o !== 1'b1 || rf_rd_o !== 5'd7 || wb_err_o !== 1'b1) begin bad++;
            $display("FAIL err_set: got wren=%0b rd=%0d err=%0b want 1/7/1",
                     rf_wren_o, rf_rd_o, wb_err_o); end
        step(); step(); step();
        #1;
        total++; if (wb_err_o !== 1'b1) begin bad++;
            $display("FAIL err_sticky: got %0b want 1", wb_err_o); end
    endtask

    task automatic test_rst_mid();
        issue_valid_i = 1; issue_wr_i = 1; issue_rd_i = 12;
        step();
        idle_inputs();
        lsu_valid_i = 1; lsu_rd_i = 12; lsu_data_i = 32'hC0DE;
        step();
        rst = 1'b1;
        lsu_valid_i = 0; alu_valid_i = 1; alu_rd_i = 3;
        #1;
        total++; if (rf_wren_o !== 1'b0 || issue_stall_o !== 1'b1 ||
                     alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin bad++;
            $display("FAIL rstmid_comb: got wren=%0b stall=%0b ar=%0b lr=%0b want 0/1/0/0",
                     rf_wren_o, issue_stall_o, alu_ready_o, lsu_ready_o); end
        step();
        #1;
        total++; if (busy_o !== 32'h0 || wb_err_o !== 1'b0 || rf_wren_o !== 1'b0) begin bad++;
            $display("FAIL rstmid_state: got busy=%0h err=%0b wren=%0b want 0/0/0",
                     busy_o, wb_err_o, rf_wren_o); end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

`ifdef RF_BYPASS_EN
    task automatic test_bypass();
        issue_valid_i = 1; issue_wr_i = 1; issue_rd_i = 3;
        step();
        idle_inputs();
        lsu_valid_i = 1; lsu_rd_i = 3; lsu_data_i = 32'hABCD;
        step();
        lsu_valid_i = 0;
        issue_valid_i = 1; issue_rs2_i = 3;
        #1;
        total++; if (issue_stall_o !== 1'b0 || fwd_rs2_o !== 1'b1 ||
                     fwd_rs1_o !== 1'b0 || fwd_data_o !== 32'hABCD) begin bad++;
            $display("FAIL bypass: got stall=%0b f2=%0b f1=%0b d=%0h want 0/1/0/abcd",
                     issue_stall_o, fwd_rs2_o, fwd_rs1_o, fwd_data_o); end
        step();
        idle_inputs();
        step();
    endtask
`endif

    task automatic test_random();
        int g;
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 79) == 0);
            issue_valid_i = $urandom_range(0, 1);
            issue_wr_i    = $urandom_range(0, 1);
            issue_rs1_i   = 5'($urandom_range(0, 7));
            issue_rs2_i   = 5'($urandom_range(0, 7));
            issue_rd_i    = 5'($urandom_range(0, 7));
            if (!alu_valid_i && $urandom_range(0, 2) == 0) begin
                alu_valid_i = 1;
                alu_rd_i    = 5'($urandom_range(0, 7));
                alu_data_i  = $urandom;
            end
            if (!lsu_valid_i && $urandom_range(0, 2) == 0) begin
                lsu_valid_i = 1;
                lsu_rd_i    = 5'($urandom_range(0, 7));
                lsu_data_i  = $urandom;
            end
            #1;
            g = m_grant();
            total++; if (issue_stall_o !== m_stall()) begin bad++;
                $display("FAIL rnd_stall: cyc %0d got %0b want %0b", c, issue_stall_o, m_stall()); end
            total++; if (alu_ready_o !== (g == 1) || lsu_ready_o !== (g == 2)) begin bad++;
                $display("FAIL rnd_grant: cyc %0d got ar=%0b lr=%0b want grant %0d",
                         c, alu_ready_o, lsu_ready_o, g); end
            total++; if (rf_wren_o !== (wren_m && !rst)) begin bad++;
                $display("FAIL rnd_wren: cyc %0d got %0b want %0b", c, rf_wren_o, wren_m && !rst); end
            if (wren_m && !rst) begin
                total++; if (rf_rd_o !== rd_m || rf_data_o !== data_m) begin bad++;
                    $display("FAIL rnd_wdata: cyc %0d got %0h/%0h want %0h/%0h",
                             c, rf_rd_o, rf_data_o, rd_m, data_m); end
            end
            total++; if (busy_o !== busy_m || wb_err_o !== err_m) begin bad++;
                $display("FAIL rnd_state: cyc %0d got busy=%0h err=%0b want %0h/%0b",
                         c, busy_o, wb_err_o, busy_m, err_m); end
            step();
            if (g == 1) alu_valid_i = 0;
            if (g == 2) lsu_valid_i = 0;
        end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    initial begin
        busy_m = '0; cnt_m = 0; wren_m = 1'b0;
        rd_m = '0; data_m = '0; err_m = 1'b0;
        test_reset();
        test_raw();
        test_starvation();
        test_rd0();
        test_err();
        test_rst_mid();
`ifdef RF_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
